hilf_n_shaper: RTL

- Parametrised successor to the fixed 18-input first-order ISI shaping loop filter in the DAC digital path.
- Takes an N-bit up-transition vector and produces N per-element shaped filter outputs for the downstream element selector.
- Adds run-time first/second order selection, configurable channel count and state width, an overflow flag, and automatic state flush on order change.

---
 rtl/hilf_n_shaper_pkg.sv | 20 ++
 rtl/hilf_n_shaper_min_tree.sv | 35 +++
 rtl/hilf_n_shaper.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hilf_n_shaper_pkg.sv
// hilf_pkg: shared definitions for the N-channel ISI shaping loop filter.
//   order_e   : shaping order encoding (ORDER_1ST / ORDER_2ND)
//   sr_width  : width of the signed datapath intermediates for a W-bit state
//   ch_lsb    : LSB position of channel i inside a packed N*W bus
package hilf_pkg;

  typedef enum logic {
    ORDER_1ST = 1'b0,
    ORDER_2ND = 1'b1
  } order_e;

  function automatic int unsigned sr_width(input int unsigned w);
    return w + 3;
  endfunction

  function automatic int unsigned ch_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/hilf_n_shaper_min_tree.sv
// hilf_min_tree: balanced combinational signed-minimum reduction.
//   din  : N packed signed words of DW bits, word i at [i*DW +: DW]
//   dmin : signed minimum of all N words
// Leaves beyond N are padded with word 0, which cannot change the minimum.
module hilf_min_tree #(
  parameter int unsigned N  = 18,
  parameter int unsigned DW = 7
) (
  input  logic [N*DW-1:0]        din,
  output logic signed [DW-1:0]   dmin
);

  localparam int unsigned P = 2 ** $clog2(N);

  // Heap layout: node 1 is the root, leaves live at P .. 2P-1.
  logic signed [DW-1:0] node [1:2*P-1];

  always_comb begin
    for (int unsigned i = 1; i < 2 * P; i++) begin
      node[i] = '0;
    end
    for (int unsigned i = 0; i < P; i++) begin
      if (i < N) begin
        node[P + i] = din[i*DW +: DW];
      end else begin
        node[P + i] = din[DW-1:0];
      end
    end
    for (int unsigned k = P - 1; k >= 1; k--) begin
      node[k] = (node[2*k] < node[2*k+1]) ? node[2*k] : node[2*k+1];
    end
    dmin = node[1];
  end

endmodule

// File: rtl/hilf_n_shaper.sv
// hilf_n_shaper: N-channel first/second-order ISI shaping loop filter.
//   clk, rst   : clock, synchronous active-high reset
//   clk_en     : state-update strobe
//   order_sel  : 0 = 1st-order, 1 = 2nd-order shaping
//   st         : up-transition vector, bit i -> channel i
//   sfi        : shaped outputs, channel i at [i*W +: W] (combinational from st)
//   ovf        : sticky overflow flag, ovf_clr clears it (set wins)
// Build option: define HILF_SAT_EN to clamp outputs to 2^W-1 and enable ovf;
// otherwise outputs wrap modulo 2^W and ovf is tied low.
module hilf_n_shaper
  import hilf_pkg::*;
#(
  parameter int unsigned N = 18,
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           order_sel,
  input  logic [N-1:0]   st,
  output logic [N*W-1:0] sfi,
  output logic           ovf,
  input  logic           ovf_clr
);

  localparam int unsigned SW = sr_width(W);

  logic [W-1:0]         fid1_q [N];
  logic [W-1:0]         fid1_d [N];
  logic [W-1:0]         fid2_q [N];
  logic [W-1:0]         fid2_d [N];
  order_e               order_q, order_d;
  logic                 ovf_q, ovf_d;

  logic signed [SW-1:0] sr [N];
  logic signed [SW-1:0] fi [N];
  logic [W-1:0]         fo [N];
  logic [N*SW-1:0]      sr_flat;
  logic signed [SW-1:0] su;
  logic                 any_over;
  logic                 flush;
  logic                 upd;

  // Residue per channel; the datapath follows order_sel directly so the
  // mismatch (flush) cycle already shows the newly selected order.
  always_comb begin
    sr_flat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      logic signed [SW-1:0] s0, f1, f2;
      s0 = SW'(st[i]);
      f1 = SW'(fid1_q[i]);
      f2 = SW'(fid2_q[i]);
      if (order_sel == ORDER_2ND) begin
        sr[i] = s0 + (f1 <<< 1) - f2;
      end else begin
        sr[i] = s0 + f1;
      end
      sr_flat[i*SW +: SW] = sr[i];
    end
  end

  hilf_min_tree #(
    .N  (N),
    .DW (SW)
  ) u_min (
    .din  (sr_flat),
    .dmin (su)
  );

`ifdef HILF_SAT_EN
  localparam logic signed [SW-1:0] MAXV = SW'((1 << W) - 1);

  always_comb begin
    any_over = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      fi[i] = sr[i] - su;
      if (fi[i] > MAXV) begin
        fo[i]    = '1;
        any_over = 1'b1;
      end else begin
        fo[i] = fi[i][W-1:0];
      end
    end
  end
`else
  logic unused_wrap;

  always_comb begin
    any_over    = 1'b0;
    unused_wrap = ovf_clr;
    for (int unsigned i = 0; i < N; i++) begin
      fi[i]       = sr[i] - su;
      fo[i]       = fi[i][W-1:0];
      unused_wrap = unused_wrap ^ (^fi[i][SW-1:W]);
    end
  end
`endif

  always_comb begin
    sfi = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sfi[ch_lsb(i, W) +: W] = fo[i];
    end
  end

  // Next state: an order change flushes both delay lines for one cycle,
  // independent of clk_en; otherwise update only on enabled edges.
  always_comb begin
    order_d = order_e'(order_sel);
    flush   = (order_e'(order_sel) != order_q);
    upd     = clk_en && !flush;
    for (int unsigned i = 0; i < N; i++) begin
      fid1_d[i] = fid1_q[i];
      fid2_d[i] = fid2_q[i];
      if (flush) begin
        fid1_d[i] = '0;
        fid2_d[i] = '0;
      end else if (upd) begin
        fid1_d[i] = fo[i];
        fid2_d[i] = fid1_q[i];
      end
    end
`ifdef HILF_SAT_EN
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (upd && any_over) begin
      ovf_d = 1'b1;
    end
`else
    ovf_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        fid1_q[i] <= '0;
        fid2_q[i] <= '0;
      end
      order_q <= ORDER_1ST;
      ovf_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        fid1_q[i] <= fid1_d[i];
        fid2_q[i] <= fid2_d[i];
      end
      order_q <= order_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule
